// File: rtl/topk_sort_relu.sv
// topk_sort_relu -- streaming top-K selector with optional ReLU.
//
// Accepts one signed score + index per cycle (in_valid/in_ready), keeps the
// best K entries of a frame in a sorted register table and, after the beat
// flagged in_last, drains them in rank order (out_valid/out_ready).
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_data, in_index    signed score and its index
//   in_last              final beat of the frame
//   asce                 1: keep smallest K, ascending; 0: keep largest K,
//                        descending (sampled on the first beat of a frame)
//   clear                synchronous flush, overrides everything but reset
//   out_valid/out_ready  output handshake
//   out_data, out_index  ranked entry at rd_ptr
//   out_last             last ranked entry
//   count                occupied slots
//
// Build option: define RELU_EN to store max(in_data,0) instead of raw values.

// One table slot. A slot is "better" when the incoming value belongs in or
// above it. Because the table is kept sorted and empty slots sit above the
// occupied ones, the better flags form a thermometer code: the first set
// flag is the insertion point, and every slot above it shifts up by one.
module topk_slot #(
    parameter int DW = 32,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ins,
    input  logic          asce,
    input  logic          occ,
    input  logic          prev_better,
    input  logic [DW-1:0] new_data,
    input  logic [IW-1:0] new_index,
    input  logic [DW-1:0] prev_data,
    input  logic [IW-1:0] prev_index,
    output logic          better,
    output logic [DW-1:0] data,
    output logic [IW-1:0] index
);
    // Strict compare: equal values stay ahead, so insertion is stable.
    always_comb begin
        better = !occ || (asce ? ($signed(new_data) < $signed(data))
                               : ($signed(new_data) > $signed(data)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            index <= '0;
        end else if (flush) begin
            data  <= '0;
            index <= '0;
        end else if (ins && better) begin
            if (prev_better) begin
                data  <= prev_data;
                index <= prev_index;
            end else begin
                data  <= new_data;
                index <= new_index;
            end
        end
    end
endmodule

module topk_sort_relu #(
    parameter int DW = 32,
    parameter int IW = 16,
    parameter int K  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    input  logic [IW-1:0]          in_index,
    input  logic                   in_last,
    input  logic                   asce,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [IW-1:0]          out_index,
    output logic                   out_last,
    output logic [$clog2(K+1)-1:0] count
);
    localparam int CW = $clog2(K+1);
    localparam int RW = $clog2(K);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, rd_ptr;
    logic                   asce_q, ord;
    logic                   ins, out_hs, last_hs, flush;
    logic [DW-1:0]          new_data;
    logic [K-1:0]           better, occ;
    logic [K-1:0][DW-1:0]   slot_data;
    logic [K-1:0][IW-1:0]   slot_index;

`ifdef RELU_EN
    assign new_data = in_data[DW-1] ? '0 : in_data;
`else
    assign new_data = in_data;
`endif

    // clear masks both handshakes in the same cycle.
    assign in_ready  = (state_q == FILL)  && !clear;
    assign out_valid = (state_q == DRAIN) && !clear;
    assign out_last  = out_valid && (rd_ptr == count_q - CW'(1));
    assign out_data  = (state_q == DRAIN) ? slot_data[rd_ptr[RW-1:0]]  : '0;
    assign out_index = (state_q == DRAIN) ? slot_index[rd_ptr[RW-1:0]] : '0;
    assign count     = count_q;

    assign ins     = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign last_hs = out_hs && out_last;
    assign flush   = clear || last_hs;

    // The table is empty on the first beat, so compares are don't-care there;
    // using the live asce then keeps the latch off the critical path.
    assign ord = (count_q == '0) ? asce : asce_q;

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic          pb;
        logic [DW-1:0] pd;
        logic [IW-1:0] pi;
        if (i == 0) begin : g_head
            assign pb = 1'b0;
            assign pd = '0;
            assign pi = '0;
        end else begin : g_body
            assign pb = better[i-1];
            assign pd = slot_data[i-1];
            assign pi = slot_index[i-1];
        end
        assign occ[i] = (count_q > CW'(i));

        topk_slot #(.DW(DW), .IW(IW)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .ins        (ins),
            .asce       (ord),
            .occ        (occ[i]),
            .prev_better(pb),
            .new_data   (new_data),
            .new_index  (in_index),
            .prev_data  (pd),
            .prev_index (pi),
            .better     (better[i]),
            .data       (slot_data[i]),
            .index      (slot_index[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            count_q <= '0;
            rd_ptr  <= '0;
            asce_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ins && count_q == '0)
                asce_q <= asce;
            if (flush)
                count_q <= '0;
            else if (ins && count_q != CW'(K))
                count_q <= count_q + CW'(1);
            if (flush)
                rd_ptr <= '0;
            else if (out_hs)
                rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (ins && in_last) state_d = DRAIN;
            DRAIN:   if (last_hs)        state_d = FILL;
            default: state_d = FILL;
        endcase
        if (clear)
            state_d = FILL;
    end
endmodule
